legv8_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. It fetches each instruction through a req/ack instruction-memory handshake, decodes the opcode and steps through DECODE/EXEC/MEM/WB. Each cycle it drives the datapath enables, the ALU operation and the sign-extend unit select (`seu_sel`). It sits between the instruction/data memory ports and the register file, ALU, sign-extend unit and PC register.

---
 rtl/legv8_ctrl_pkg.sv | 36 +++
 rtl/legv8_opc_decode.sv | 27 ++
 rtl/legv8_mc_ctrl.sv | 87 ++++++++
 tb/tb_legv8_mc_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared opcodes, FSM states, instruction classes and control codes
// for the legv8_mc_ctrl sequencer.
package legv8_ctrl_pkg;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    // Prefix-matched opcodes: the remaining low bits belong to the immediate field.
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP} state_t;
    typedef enum logic [3:0] {
        CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR, CLS_ADDI,
        CLS_LDUR, CLS_STUR, CLS_B, CLS_CBZ, CLS_ILL
    } cls_t;
    typedef enum logic [1:0] {SEU_ALUIMM, SEU_DT, SEU_BR, SEU_CB} seu_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;

    function automatic seu_t seu_of(cls_t c);
        return c inside {CLS_LDUR, CLS_STUR} ? SEU_DT :
               c == CLS_B ? SEU_BR : c == CLS_CBZ ? SEU_CB : SEU_ALUIMM;
    endfunction

    function automatic alu_op_t alu_op_of(cls_t c);
        return c inside {CLS_SUB, CLS_CBZ} ? ALU_SUB :
               c == CLS_AND ? ALU_AND : c == CLS_ORR ? ALU_ORR : ALU_ADD;
    endfunction

    function automatic logic alu_src_of(cls_t c);
        return c inside {CLS_ADDI, CLS_LDUR, CLS_STUR};
    endfunction
endpackage

// File: rtl/legv8_opc_decode.sv
// legv8_opc_decode: combinational opcode classifier; CBZ is recognised only
// when LEGV8_CBZ_EN is defined, otherwise it falls into the illegal class.
module legv8_opc_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opc,
    output cls_t        cls,
    output logic        ill
);
`ifdef LEGV8_CBZ_EN
    localparam logic CBZ_EN = 1'b1;
`else
    localparam logic CBZ_EN = 1'b0;
`endif
    always_comb begin
        cls = opc == OPC_ADD  ? CLS_ADD  :
              opc == OPC_SUB  ? CLS_SUB  :
              opc == OPC_AND  ? CLS_AND  :
              opc == OPC_ORR  ? CLS_ORR  :
              opc[10:1] == OPC_ADDI ? CLS_ADDI :
              opc == OPC_LDUR ? CLS_LDUR :
              opc == OPC_STUR ? CLS_STUR :
              opc[10:5] == OPC_B ? CLS_B :
              (CBZ_EN && opc[10:3] == OPC_CBZ) ? CLS_CBZ : CLS_ILL;
        ill = cls == CLS_ILL;
    end
endmodule

// File: rtl/legv8_mc_ctrl.sv
// legv8_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for LEGv8.
// Optional CBZ support is enabled by defining LEGV8_CBZ_EN.
module legv8_mc_ctrl
    import legv8_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_we,
    input  logic [10:0] instr_opc,
    input  logic        alu_zero,
    output logic [1:0]  seu_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        pc_we,
    output logic        pc_src,
    output logic        illegal
);
    state_t state, state_nx;
    cls_t   cls_q, dec_cls, cls;
    logic   dec_ill, run_q, act;
    logic   unused_rdata;

    assign unused_rdata = ^imem_rdata;

    legv8_opc_decode u_dec (.opc(instr_opc), .cls(dec_cls), .ill(dec_ill));

    // run_q keeps every request low while rst_n is asserted, although state already sits in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            cls_q <= CLS_ILL;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            state <= state_nx;
            if (state == ST_DECODE) cls_q <= dec_cls;
        end
    end

    always_comb begin
        state_nx   = state;
        act        = state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
        cls        = state == ST_DECODE ? dec_cls : cls_q;
        imem_req   = run_q && state == ST_FETCH;
        ir_we      = imem_req && imem_ack;
        seu_sel    = act ? seu_of(cls) : SEU_ALUIMM;
        alu_src    = act && alu_src_of(cls);
        alu_op     = act ? alu_op_of(cls) : ALU_ADD;
        dmem_req   = state == ST_MEM;
        dmem_we    = dmem_req && cls == CLS_STUR;
        reg_we     = state == ST_WB;
        mem_to_reg = reg_we && cls == CLS_LDUR;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        illegal    = state == ST_TRAP;
        case (state)
            ST_FETCH:  state_nx = ir_we ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_nx = dec_ill ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (cls inside {CLS_B, CLS_CBZ}) begin
                    pc_we    = 1'b1;
                    pc_src   = cls == CLS_B || alu_zero;
                    state_nx = ST_FETCH;
                end else begin
                    state_nx = cls inside {CLS_LDUR, CLS_STUR} ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                pc_we    = dmem_ack && cls == CLS_STUR;
                state_nx = !dmem_ack ? ST_MEM : cls == CLS_LDUR ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                pc_we    = 1'b1;
                state_nx = ST_FETCH;
            end
            default: state_nx = state;
        endcase
    end
endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// tb_legv8_mc_ctrl: directed plus randomized checks of legv8_mc_ctrl against a
// per-instruction timeline model derived from the opcode class and handshake waits.
module tb_legv8_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ir_we;
    logic [10:0] instr_opc = '0;
    logic        alu_zero = 1'b0;
    logic [1:0]  seu_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        reg_we, mem_to_reg, pc_we, pc_src, illegal;
    int          tests = 0;
    int          fails = 0;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4;
    localparam int K_LD = 5, K_ST = 6, K_B = 7, K_CBZ = 8, K_ILL = 9;

    // Opcode patterns as value/mask pairs, indexed by kind.
    logic [10:0] pat_v [9] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                               11'b10010001000, 11'b11111000010, 11'b11111000000, 11'b00010100000,
                               11'b10110100000};
    logic [10:0] pat_m [9] = '{11'h7ff, 11'h7ff, 11'h7ff, 11'h7ff, 11'h7fe, 11'h7ff, 11'h7ff,
                               11'h7e0, 11'h7f8};
    int seu_k [10] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 0};
    int aop_k [10] = '{0, 1, 2, 3, 0, 0, 0, 0, 1, 0};
    int src_k [10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    legv8_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_we(ir_we), .instr_opc(instr_opc), .alu_zero(alu_zero),
        .seu_sel(seu_sel), .alu_src(alu_src), .alu_op(alu_op), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .pc_we(pc_we), .pc_src(pc_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic int kind_of(input logic [10:0] o);
        for (int i = 0; i < 9; i++) begin
`ifndef LEGV8_CBZ_EN
            if (i == K_CBZ) continue;
`endif
            if ((o & pat_m[i]) == pat_v[i]) return i;
        end
        return K_ILL;
    endfunction

    function automatic logic [10:0] rand_opc(input int k);
        logic [10:0] r;
        r = 11'($urandom);
        return (pat_v[k] & pat_m[k]) | (r & ~pat_m[k]);
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_ireq, input logic e_irwe,
                              input logic [1:0] e_seu, input logic e_src, input logic [1:0] e_aop,
                              input logic e_dreq, input logic e_dwe, input logic e_rwe,
                              input logic e_m2r, input logic e_pcwe, input logic e_pcsrc,
                              input logic e_ill);
        chk({tag, ".imem_req"}, {1'b0, imem_req}, {1'b0, e_ireq});
        chk({tag, ".ir_we"}, {1'b0, ir_we}, {1'b0, e_irwe});
        chk({tag, ".seu_sel"}, seu_sel, e_seu);
        chk({tag, ".alu_src"}, {1'b0, alu_src}, {1'b0, e_src});
        chk({tag, ".alu_op"}, alu_op, e_aop);
        chk({tag, ".dmem_req"}, {1'b0, dmem_req}, {1'b0, e_dreq});
        chk({tag, ".dmem_we"}, {1'b0, dmem_we}, {1'b0, e_dwe});
        chk({tag, ".reg_we"}, {1'b0, reg_we}, {1'b0, e_rwe});
        chk({tag, ".mem_to_reg"}, {1'b0, mem_to_reg}, {1'b0, e_m2r});
        chk({tag, ".pc_we"}, {1'b0, pc_we}, {1'b0, e_pcwe});
        chk({tag, ".pc_src"}, {1'b0, pc_src}, {1'b0, e_pcsrc});
        chk({tag, ".illegal"}, {1'b0, illegal}, {1'b0, e_ill});
    endtask

    task automatic drive_noise();
        imem_ack   = 1'($urandom);
        dmem_ack   = 1'($urandom);
        alu_zero   = 1'($urandom);
        instr_opc  = 11'($urandom);
        imem_rdata = $urandom;
    endtask

    // Timeline of one legal instruction: fetch ends at fe, decode at d, exec at e,
    // memory spans ms..me, write-back at w (0 = none), last cycle is total.
    task automatic run_instr(input string tag, input logic [10:0] opc, input int iw,
                             input int dw, input logic az, input int abort_at);
        int kd, fe, d, e, ms, me, w, total;
        bit mem, act, dreq, rwe, pcwe;
        kd = kind_of(opc);
        fe = iw + 1; d = fe + 1; e = d + 1; ms = e + 1; me = ms + dw;
        mem = kd == K_LD || kd == K_ST;
        total = (kd == K_B || kd == K_CBZ) ? e : kd == K_ST ? me : kd == K_LD ? me + 1 : e + 1;
        w = (kd == K_B || kd == K_CBZ || kd == K_ST) ? 0 : total;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            drive_noise();
            imem_ack   = k <= fe ? k == fe : 1'($urandom);
            imem_rdata = {opc, 21'($urandom)};
            if (k > fe) instr_opc = opc;
            if (mem && k >= ms && k <= me) dmem_ack = k == me;
            if (k == e) alu_zero = az;
            #1;
            act  = k >= d;
            dreq = mem && k >= ms && k <= me;
            rwe  = k == w;
            pcwe = k == total;
            check_outs($sformatf("%s.c%0d", tag, k), k <= fe, k == fe,
                       act ? 2'(seu_k[kd]) : 2'd0, act && src_k[kd] == 1,
                       act ? 2'(aop_k[kd]) : 2'd0, dreq, dreq && kd == K_ST, rwe,
                       rwe && kd == K_LD, pcwe,
                       pcwe && (kd == K_B || (kd == K_CBZ && az)), 1'b0);
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_outs({tag, ".abort"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                return;
            end
        end
    endtask

    task automatic run_trap(input string tag, input logic [10:0] opc);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            drive_noise();
            if (k == 1) imem_ack = 1'b1;
            if (k >= 2) instr_opc = opc;
            #1;
            check_outs($sformatf("%s.c%0d", tag, k), k == 1, k == 1, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, k >= 3);
        end
    endtask

    task automatic run_any(input string tag, input logic [10:0] opc, input int iw,
                           input int dw, input logic az);
        if (kind_of(opc) == K_ILL) run_trap(tag, opc);
        else run_instr(tag, opc, iw, dw, az, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive_noise();
        #1 check_outs({tag, ".async"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            drive_noise();
            #1 check_outs({tag, ".hold"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("reset");
        run_instr("add", 11'b10001011000, 0, 0, 0, 0);
        run_instr("sub", 11'b11001011000, 1, 0, 0, 0);
        run_instr("and", 11'b10001010000, 2, 0, 0, 0);
        run_instr("orr", 11'b10101010000, 0, 0, 1, 0);
        run_instr("addi", 11'b10010001001, 1, 0, 0, 0);
        run_instr("ldur_w3", 11'b11111000010, 0, 3, 0, 0);
        run_instr("stur_w1", 11'b11111000000, 0, 1, 0, 0);
        run_instr("stur_w0", 11'b11111000000, 1, 0, 1, 0);
        run_instr("b", 11'b00010110101, 0, 0, 0, 0);
        run_any("cbz_z1", 11'b10110100000, 0, 0, 1);
        if (kind_of(11'b10110100000) == K_ILL) do_reset("cbz_trap_rst");
        else run_any("cbz_z0", 11'b10110100101, 1, 0, 0);
        for (int n = 0; n < 60; n++) begin
            logic [10:0] o;
            o = rand_opc($urandom_range(0, 8));
            if (kind_of(o) == K_ILL) o = rand_opc(K_ADDI);
            run_instr($sformatf("rnd%0d", n), o, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 0);
        end
        run_instr("ldur_abort", 11'b11111000010, 0, 3, 0, 5);
        repeat (3) begin
            @(negedge clk);
            drive_noise();
            dmem_ack = 1'b1;
            #1 check_outs("abort_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        run_instr("add_after_abort", 11'b10001011000, 0, 0, 0, 0);
        run_trap("trap", 11'b00000000000);
        do_reset("trap_rst");
        run_instr("add_after_trap", 11'b10001011000, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
